// File: rtl/axi_burst_master_64.sv
// AXI4 burst initiator for 64-bit data. Each command runs one single-ID INCR
// burst: a write pulls its beats from a local stream, and a read pushes the
// returned beats to a local stream. Only one burst is outstanding at a time.
// A command whose burst would cross a 4 KB page is rejected without any bus
// activity.
//
//   state | meaning
//   IDLE  | waiting for a command (cmd_ready high unless done is pulsing)
//   AW    | write address offered, waiting for awready
//   W     | write beats passed through from wr_* to m_w*
//   B     | waiting for the write response
//   AR    | read address offered, waiting for arready
//   R     | read beats passed through from m_r* to rd_*
//   REJ   | command crosses a 4 KB boundary; flag it and finish
module axi_burst_master_64 #(
    parameter int DW = 64,
    parameter int LW = 8,
    parameter int IW = 4
) (
    input  logic            s_aclk,
    input  logic            s_aresetn,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_rw,
    input  logic [31:0]     cmd_addr,
    input  logic [LW-1:0]   cmd_len,
    output logic            busy,
    output logic            done,
    output logic [1:0]      resp,
    output logic            err_4k,
    output logic            err_last,

    input  logic [DW-1:0]   wr_data,
    input  logic            wr_valid,
    output logic            wr_ready,
    output logic [DW-1:0]   rd_data,
    output logic            rd_valid,
    input  logic            rd_ready,

    output logic [31:0]     m_awaddr,
    output logic [LW-1:0]   m_awlen,
    output logic [2:0]      m_awsize,
    output logic [1:0]      m_awburst,
    output logic [IW-1:0]   m_awid,
    output logic            m_awvalid,
    input  logic            m_awready,

    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    output logic            m_wlast,
    output logic            m_wvalid,
    input  logic            m_wready,

    input  logic [IW-1:0]   m_bid,
    input  logic [1:0]      m_bresp,
    input  logic            m_bvalid,
    output logic            m_bready,

    output logic [31:0]     m_araddr,
    output logic [LW-1:0]   m_arlen,
    output logic [2:0]      m_arsize,
    output logic [1:0]      m_arburst,
    output logic [IW-1:0]   m_arid,
    output logic            m_arvalid,
    input  logic            m_arready,

    input  logic [IW-1:0]   m_rid,
    input  logic [DW-1:0]   m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic            m_rlast,
    input  logic            m_rvalid,
    output logic            m_rready
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_REJ
    } state_t;

    state_t          state;
    logic [31:0]     addr_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   beat_cnt;
    logic            awvalid_q;
    logic            arvalid_q;
    logic            bready_q;
    logic            busy_q;
    logic            done_q;
    logic [1:0]      resp_q;
    logic            err_4k_q;
    logic            err_last_q;

    logic [12:0]     span_end;
    logic            cross_4k;
    logic            last_beat;
    logic            in_w;
    logic            in_r;
    logic            unused_inputs;

    // End of the burst within its 4 KB page; one past the page end is legal.
    assign span_end  = {1'b0, cmd_addr[11:3], 3'b000}
                     + (({{(13-LW){1'b0}}, cmd_len} + 13'd1) << 3);
    assign cross_4k  = span_end > 13'h1000;
    assign last_beat = (beat_cnt == len_q);
    assign in_w      = (state == ST_W);
    assign in_r      = (state == ST_R);

    // Beat IDs are not checked and the low address bits are always dropped.
    assign unused_inputs = ^{m_bid, m_rid, cmd_addr[2:0]};

    // Main sequencer: command accept, address/data/response phases, flags.
    always_ff @(posedge s_aclk) begin
        if (!s_aresetn) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
            awvalid_q  <= 1'b0;
            arvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            resp_q     <= 2'b00;
            err_4k_q   <= 1'b0;
            err_last_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The done cycle is spent in IDLE with busy still high.
                    if (done_q) begin
                        busy_q <= 1'b0;
                    end else if (cmd_valid) begin
                        addr_q     <= {cmd_addr[31:3], 3'b000};
                        len_q      <= cmd_len;
                        beat_cnt   <= '0;
                        resp_q     <= 2'b00;
                        err_4k_q   <= 1'b0;
                        err_last_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (cross_4k) begin
                            state <= ST_REJ;
                        end else if (cmd_rw) begin
                            state     <= ST_AR;
                            arvalid_q <= 1'b1;
                        end else begin
                            state     <= ST_AW;
                            awvalid_q <= 1'b1;
                        end
                    end
                end
                ST_REJ: begin
                    err_4k_q <= 1'b1;
                    done_q   <= 1'b1;
                    state    <= ST_IDLE;
                end
                ST_AW: begin
                    if (m_awready) begin
                        awvalid_q <= 1'b0;
                        state     <= ST_W;
                    end
                end
                ST_W: begin
                    if (wr_valid && m_wready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            bready_q <= 1'b1;
                            state    <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (m_bvalid) begin
                        if (m_bresp != 2'b00 && resp_q == 2'b00)
                            resp_q <= m_bresp;
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_AR: begin
                    if (m_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= ST_R;
                    end
                end
                ST_R: begin
                    if (m_rvalid && rd_ready) begin
                        if (m_rresp != 2'b00 && resp_q == 2'b00)
                            resp_q <= m_rresp;
                        if (m_rlast != last_beat)
                            err_last_q <= 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                        // An early rlast truncates the burst.
                        if (last_beat || m_rlast) begin
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE) && !done_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign resp      = resp_q;
    assign err_4k    = err_4k_q;
    assign err_last  = err_last_q;

    assign m_awaddr  = addr_q;
    assign m_awlen   = len_q;
    assign m_awsize  = 3'b011;
    assign m_awburst = 2'b01;
    assign m_awid    = '0;
    assign m_awvalid = awvalid_q;

    assign m_wdata   = wr_data;
    assign m_wstrb   = '1;
    assign m_wlast   = in_w && last_beat;
    assign m_wvalid  = in_w && wr_valid;
    assign wr_ready  = in_w && m_wready;

    assign m_bready  = bready_q;

    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arsize  = 3'b011;
    assign m_arburst = 2'b01;
    assign m_arid    = '0;
    assign m_arvalid = arvalid_q;

    assign rd_data   = m_rdata;
    assign rd_valid  = in_r && m_rvalid;
    assign m_rready  = in_r && rd_ready;

endmodule

// File: doc/axi_burst_master_64.md
# axi_burst_master_64

AXI4 initiator that executes one single-ID INCR burst per command: it writes a stream of 64-bit words to a memory-mapped slave, or reads a burst back into a stream. It sits on the initiator side of the 64-bit AXI fabric. It drives injection and capture memories and other register-mapped slaves from local control logic, such as a test sequencer or a playback controller. Only one transaction is outstanding at any time.

## Interface
- DW, 64, data width; fixed at 64 (AxSIZE = 3'b011).
- LW, 8, AXI length width; cmd_len is the AXI length, so beats = cmd_len + 1 (1..256).
- s_aclk  in  1  sole clock; all logic is on its rising edge.
- s_aresetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_rw  in  1  0 = write burst, 1 = read burst.
- cmd_addr  in  32  byte address; bits [2:0] are ignored and driven as 0.
- cmd_len  in  8  beats − 1.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse when a command ends.
- resp  out  2  first non-OKAY BRESP/RRESP of the command; 2'b00 if all beats were OKAY.
- err_4k  out  1  command rejected because it crosses a 4 KB boundary.
- err_last  out  1  read RLAST did not coincide with the final beat.
- wr_data  in  64  write stream data.
- wr_valid  in  1  write stream data valid.
- wr_ready  out  1  write stream ready.
- rd_data  out  64  read stream data.
- rd_valid  out  1  read stream data valid.
- rd_ready  in  1  read stream ready.
- m_awaddr/awlen/awsize/awburst/awid/awvalid, m_awready: AXI4 write-address channel (awid = 0, awburst = 2'b01).
- m_wdata/wstrb/wlast/wvalid, m_wready: write-data channel; wstrb = 8'hFF.
- m_bid/bresp/bvalid, m_bready: write-response channel.
- m_araddr/arlen/arsize/arburst/arid/arvalid, m_arready: read-address channel (arid = 0, arburst = 2'b01).
- m_rid/rdata/rresp/rlast/rvalid, m_rready: read-data channel.

## Operation
- States: IDLE, AW, W, B, AR, R, REJ.
- IDLE:
  - On cmd_valid, latch rw, addr (with [2:0] cleared) and len; clear resp, err_4k and err_last; clear beat_cnt (8 bit).
  - 4 KB check, computed in 13-bit arithmetic: {1'b0, addr[11:0]} + ((len + 1) << 3) > 13'h1000 → go to REJ.
  - Otherwise go to AW if rw = 0, or AR if rw = 1.
- REJ: set err_4k and pulse done; no AXI activity; return to IDLE.
- AW: awvalid = 1 with awaddr and awlen held stable until awready; on the handshake go to W.
- W: the data path is combinational pass-through.
  - m_wvalid = wr_valid, wr_ready = m_wready, wdata = wr_data.
  - wlast = (beat_cnt == len).
  - Each wvalid & wready increments beat_cnt; the handshake on the last beat goes to B.
- B: bready = 1. On bvalid, record bresp if it is non-OKAY and resp is still 00. Pulse done and return to IDLE.
- AR: arvalid is held until arready, then go to R.
- R: the data path is combinational pass-through.
  - rd_valid = m_rvalid, m_rready = rd_ready, rd_data = m_rdata.
  - Each beat handshake: record the first non-OKAY rresp; set err_last if rlast ≠ (beat_cnt == len); increment beat_cnt.
  - The transaction ends on the handshake where beat_cnt == len, or where rlast = 1, whichever comes first. At that point pulse done and return to IDLE.
  - If rlast arrives early, the burst is truncated.
- Outside W, wr_ready = 0 and wvalid = 0. Outside R, rd_valid = 0 and rready = 0.
- Inbound bid and rid are ignored.
- Reset (s_aresetn = 0 on a clock edge) in any state:
  - Return to IDLE.
  - All valid and ready outputs, busy, done, err_4k, err_last and beat_cnt go to 0; resp goes to 00.
  - An in-flight burst is abandoned; the slave must be reset in the same domain.

## Timing
- cmd_ready = 1 in IDLE, so a command is accepted in the cycle cmd_valid is high.
- awvalid or arvalid rises in the next cycle. Minimum AW-to-W gap: the first wvalid can appear in the cycle after the AW handshake.
- Minimum write burst of N beats, counted from command accept to done (inclusive), with an always-ready slave: 1 (AW) + N (W) + 1 (B) cycles after the accept cycle. done is registered and asserted in the cycle after the B handshake.
- Read: done is asserted in the cycle after the final R handshake.
- busy is registered: high from the cycle after accept through the done cycle, low in the cycle after done.
- Back-to-back commands: cmd_ready returns in the cycle after done.
- All AXI outputs are stable while valid is high and ready is low.

## Test plan
- Write burst, addr 0x0000_1000, len 3, slave always ready, data 1..4 → AW(awaddr 0x1000, awlen 3, awsize 3, awburst 1) then 4 W beats with wlast on beat 4 only, then bready. done fires once with resp 00.
- Read burst, addr 0x0000_0FF8, len 0 → a single R beat is passed to rd_data. done fires with err_4k = 0 (the burst ends exactly at the 4 KB boundary).
- Command addr 0x0000_0FF8, len 1 → REJ: no awvalid or arvalid asserted, done with err_4k = 1.
- Read len 7 with a slave that returns rresp 2'b10 on beat 3 and rlast on beat 5 → resp 10, err_last = 1, done after beat 5. Random rd_ready stalls hold rready = 0.
- Write len 15 with random wr_valid and m_wready gaps → exactly 16 handshakes and wlast on the 16th. s_aresetn is pulsed low at beat 8 in a repeat run: all outputs reach reset values on the next edge and the block returns to IDLE.
